// File: rtl/median_filter_pkg.sv
// Shared definitions for the median filter RX/TX framers: FSM encodings,
// aux sideband bit positions and the line FIFO word layout.
package median_filter_pkg;

    typedef enum logic [1:0] {
        MF_RX_IDLE  = 2'd0,
        MF_RX_RECV  = 2'd1,
        MF_RX_PAD   = 2'd2,
        MF_RX_DRAIN = 2'd3
    } mf_rx_state_e;

    localparam int AUX_SOF  = 0;
    localparam int AUX_EOL  = 1;
    localparam int AUX_CORE = 2;

    // The mask bit sits directly above the pixel in every line FIFO word.
    function automatic int mf_mask_pos(input int dw_vd);
        return dw_vd;
    endfunction

endpackage

// File: rtl/median_filter_rx.sv
// Receive-side framer: writes masked pixels into the line FIFO cascade and
// appends SIZE/2 padding lines per frame. Optional checks: MF_RX_ERR_CHK_EN.
module median_filter_rx
    import median_filter_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int DW_VD = 14,
    parameter int DW_VX = 4,
    parameter int DW_MD = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [DW_MD-1:0] iw,
    input  logic [DW_MD-1:0] ih,
    input  logic [DW_VX-1:0] aux,
    input  logic [DW_VD-1:0] dat,
    input  logic             val,
    output logic             rdy,
    input  logic             line_fifo_afull,
    output logic             line_wr_en,
    output logic [DW_VD:0]   line_wr_dat,
    output logic [15:0]      rcvd_line_cntr,
    input  logic [15:0]      sent_line_cntr,
    output logic             frame_err
);

    localparam int PAD_LINES = SIZE / 2;
    localparam int MASK_POS  = mf_mask_pos(DW_VD);

    mf_rx_state_e     state_q, state_d;
    logic [DW_MD-1:0] iw_q, iw_d;
    logic [DW_MD-1:0] ih_q, ih_d;
    logic [DW_MD-1:0] pix_cntr_q, pix_cntr_d;
    logic [DW_MD-1:0] line_cntr_q, line_cntr_d;
    logic [DW_MD-1:0] pad_pix_q, pad_pix_d;
    logic [DW_MD-1:0] pad_line_q, pad_line_d;
    logic [15:0]      rcvd_q, rcvd_d;
    logic             wr_en_q, wr_en_d;
    logic [DW_VD:0]   wr_dat_q, wr_dat_d;

    logic             accept;
    logic             sof;
    logic             eol;
    logic             take_pixel;
    logic             line_last;
    logic             frame_last;
    logic             pad_pix_last;
    logic             pad_line_last;
    logic             drain_done;
    logic [DW_MD-1:0] width_cur;
    logic [DW_MD-1:0] height_cur;

    assign rdy    = rstb && ((state_q == MF_RX_IDLE) || (state_q == MF_RX_RECV)) && !line_fifo_afull;
    assign accept = val && rdy;
    assign sof    = aux[AUX_SOF];
    assign eol    = aux[AUX_EOL];

    // The sof beat is compared against the live iw/ih since they latch on that same edge.
    assign width_cur  = (state_q == MF_RX_IDLE) ? iw : iw_q;
    assign height_cur = (state_q == MF_RX_IDLE) ? ih : ih_q;

    assign take_pixel    = accept && (((state_q == MF_RX_IDLE) && sof) || (state_q == MF_RX_RECV));
    assign line_last     = (pix_cntr_q == width_cur - DW_MD'(1));
    assign frame_last    = line_last && (line_cntr_q == height_cur - DW_MD'(1));
    assign pad_pix_last  = (pad_pix_q == iw_q - DW_MD'(1));
    assign pad_line_last = (pad_line_q == DW_MD'(PAD_LINES - 1));
    assign drain_done    = (32'(sent_line_cntr) == 32'(ih_q));

    always_comb begin
        state_d     = state_q;
        iw_d        = iw_q;
        ih_d        = ih_q;
        pix_cntr_d  = pix_cntr_q;
        line_cntr_d = line_cntr_q;
        pad_pix_d   = pad_pix_q;
        pad_line_d  = pad_line_q;
        rcvd_d      = rcvd_q;
        wr_en_d     = 1'b0;
        wr_dat_d    = wr_dat_q;

        case (state_q)
            MF_RX_IDLE: begin
                if (take_pixel) begin
                    iw_d    = iw;
                    ih_d    = ih;
                    state_d = MF_RX_RECV;
                end
            end
            MF_RX_RECV: begin
            end
            MF_RX_PAD: begin
                if (!line_fifo_afull) begin
                    wr_en_d  = 1'b1;
                    wr_dat_d = '0;
                    if (pad_pix_last) begin
                        pad_pix_d = '0;
                        if (pad_line_last) begin
                            pad_line_d = '0;
                            state_d    = MF_RX_DRAIN;
                        end else begin
                            pad_line_d = pad_line_q + DW_MD'(1);
                        end
                    end else begin
                        pad_pix_d = pad_pix_q + DW_MD'(1);
                    end
                end
            end
            MF_RX_DRAIN: begin
                if (drain_done) begin
                    rcvd_d      = '0;
                    line_cntr_d = '0;
                    pix_cntr_d  = '0;
                    state_d     = MF_RX_IDLE;
                end
            end
            default: state_d = MF_RX_IDLE;
        endcase

        // Line end is decided by the pixel counter alone; eol only feeds the checker.
        if (take_pixel) begin
            wr_en_d                  = 1'b1;
            wr_dat_d[MASK_POS]       = 1'b1;
            wr_dat_d[DW_VD-1:0]      = dat;
            if (line_last) begin
                pix_cntr_d  = '0;
                line_cntr_d = line_cntr_q + DW_MD'(1);
                if (32'(rcvd_q) < 32'(height_cur)) begin
                    rcvd_d = rcvd_q + 16'd1;
                end
                if (frame_last) begin
                    pad_pix_d  = '0;
                    pad_line_d = '0;
                    state_d    = (PAD_LINES == 0) ? MF_RX_DRAIN : MF_RX_PAD;
                end
            end else begin
                pix_cntr_d = pix_cntr_q + DW_MD'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= MF_RX_IDLE;
            iw_q        <= '0;
            ih_q        <= '0;
            pix_cntr_q  <= '0;
            line_cntr_q <= '0;
            pad_pix_q   <= '0;
            pad_line_q  <= '0;
            rcvd_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            iw_q        <= iw_d;
            ih_q        <= ih_d;
            pix_cntr_q  <= pix_cntr_d;
            line_cntr_q <= line_cntr_d;
            pad_pix_q   <= pad_pix_d;
            pad_line_q  <= pad_line_d;
            rcvd_q      <= rcvd_d;
            wr_en_q     <= wr_en_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

    assign line_wr_en     = wr_en_q;
    assign line_wr_dat    = wr_dat_q;
    assign rcvd_line_cntr = rcvd_q;

`ifdef MF_RX_ERR_CHK_EN
    logic err_q, err_d;
    logic aux_unused;

    assign aux_unused = ^aux[DW_VX-1:AUX_CORE];

    // Any number of violations on one beat collapse into a single pulse.
    always_comb begin
        err_d = 1'b0;
        if (accept) begin
            if ((state_q == MF_RX_IDLE) && !sof) begin
                err_d = 1'b1;
            end
            if ((state_q == MF_RX_RECV) && sof) begin
                err_d = 1'b1;
            end
            if (take_pixel && (eol != line_last)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;
`else
    logic aux_unused;

    assign aux_unused = ^{aux[DW_VX-1:AUX_CORE], eol};
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_median_filter_rx.sv
// Self-checking bench for median_filter_rx: frame-level reference model plus
// directed and randomized frames. Follows MF_RX_ERR_CHK_EN like the RTL.
`timescale 1ns/1ps
module tb_median_filter_rx;
    import median_filter_pkg::*;

    localparam int SIZE  = 3;
    localparam int DW_VD = 14;
    localparam int DW_VX = 4;
    localparam int DW_MD = 16;
`ifdef MF_RX_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic [DW_MD-1:0] iw = 16'd4;
    logic [DW_MD-1:0] ih = 16'd3;
    logic [DW_VX-1:0] aux = '0;
    logic [DW_VD-1:0] dat = '0;
    logic             val = 1'b0;
    logic             rdy;
    logic             line_fifo_afull = 1'b0;
    logic             line_wr_en;
    logic [DW_VD:0]   line_wr_dat;
    logic [15:0]      rcvd_line_cntr;
    logic [15:0]      sent_line_cntr = '0;
    logic             frame_err;

    always #5 clk = ~clk;

    median_filter_rx #(
        .SIZE  (SIZE),
        .DW_VD (DW_VD),
        .DW_VX (DW_VX),
        .DW_MD (DW_MD)
    ) dut (
        .clk             (clk),
        .rstb            (rstb),
        .iw              (iw),
        .ih              (ih),
        .aux             (aux),
        .dat             (dat),
        .val             (val),
        .rdy             (rdy),
        .line_fifo_afull (line_fifo_afull),
        .line_wr_en      (line_wr_en),
        .line_wr_dat     (line_wr_dat),
        .rcvd_line_cntr  (rcvd_line_cntr),
        .sent_line_cntr  (sent_line_cntr),
        .frame_err       (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "waiting", "receiving", "padding" or "draining";
    // outputs are what the next registered cycle must show.
    int             mdlPhase = 0;
    int             mdlW = 1;
    int             mdlH = 1;
    int             mdlRecv = 0;
    int             mdlPadLeft = 0;
    int             mdlRcvd = 0;
    bit             mdlWrEn = 1'b0;
    bit             mdlErr = 1'b0;
    logic [DW_VD:0] mdlWrDat = '0;
    int             mdlPh;
    bit             mdlXfer;
    bit             mdlTake;
    bit             mdlLast;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mdlPhase = 0;
            mdlRecv  = 0;
            mdlRcvd  = 0;
            mdlWrEn  = 1'b0;
            mdlErr   = 1'b0;
            mdlWrDat = '0;
        end else begin
            mdlPh   = mdlPhase;
            mdlXfer = val && (mdlPh <= 1) && !line_fifo_afull;
            mdlTake = mdlXfer && ((mdlPh == 1) || aux[AUX_SOF]);
            mdlWrEn = 1'b0;
            mdlErr  = 1'b0;
            if (mdlXfer && mdlPh == 0 && !aux[AUX_SOF]) mdlErr = ERR_EN;
            if (mdlXfer && mdlPh == 1 && aux[AUX_SOF]) mdlErr = ERR_EN;
            if (mdlTake) begin
                if (mdlPh == 0) begin
                    mdlW    = int'(iw);
                    mdlH    = int'(ih);
                    mdlRecv = 0;
                end
                mdlPhase = 1;
                mdlRecv++;
                mdlLast  = (mdlRecv % mdlW) == 0;
                if (aux[AUX_EOL] != mdlLast) mdlErr = ERR_EN;
                mdlWrEn  = 1'b1;
                mdlWrDat = {1'b1, dat};
                if (mdlLast) mdlRcvd = mdlRecv / mdlW;
                if (mdlRecv == mdlW * mdlH) begin
                    mdlPadLeft = (SIZE / 2) * mdlW;
                    mdlPhase   = (mdlPadLeft > 0) ? 2 : 3;
                end
            end
            if (mdlPh == 2 && !line_fifo_afull) begin
                mdlWrEn  = 1'b1;
                mdlWrDat = '0;
                mdlPadLeft--;
                if (mdlPadLeft == 0) mdlPhase = 3;
            end
            if (mdlPh == 3 && int'(sent_line_cntr) == mdlH) begin
                mdlRcvd  = 0;
                mdlPhase = 0;
            end
        end
    end

    logic [DW_VD:0] wrLog[$];
    int             rcvdLog[$];
    int             errPulses = 0;

    // Single compare point, half a cycle away from the active edge.
    always @(negedge clk) begin
        checkOutput("rdy", 32'(rdy), 32'(rstb && (mdlPhase <= 1) && !line_fifo_afull));
        checkOutput("line_wr_en", 32'(line_wr_en), 32'(mdlWrEn));
        if (mdlWrEn) checkOutput("line_wr_dat", 32'(line_wr_dat), 32'(mdlWrDat));
        checkOutput("rcvd_line_cntr", 32'(rcvd_line_cntr), 32'(mdlRcvd));
        checkOutput("frame_err", 32'(frame_err), 32'(mdlErr));
        if (line_wr_en) begin
            wrLog.push_back(line_wr_dat);
            rcvdLog.push_back(int'(rcvd_line_cntr));
        end
        if (frame_err) errPulses++;
    end

    bit afullRand = 1'b0;
    bit afullForce = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            line_fifo_afull = afullForce || (afullRand && ($urandom_range(0, 2) == 0));
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the block takes it.
    task automatic applyStimulus(input logic [DW_VD-1:0] d, input logic [DW_VX-1:0] a);
        int  waited;
        bit  taken;
        waited = 0;
        taken  = 1'b0;
        dat = d;
        aux = a;
        val = 1'b1;
        while (!taken && waited < 300) begin
            @(negedge clk);
            taken = rdy;
            nextCycle();
            waited++;
        end
        val = 1'b0;
        if (!taken) checkOutput("beat_accept_timeout", 32'(taken), 32'd1);
    endtask

    task automatic finishFrame(input int h);
        int n;
        n = 0;
        while (mdlPhase != 3 && n < 500) begin
            nextCycle();
            n++;
        end
        if (mdlPhase != 3) checkOutput("drain_timeout", 32'(mdlPhase), 32'd3);
        repeat (3) nextCycle();
        sent_line_cntr = 16'(h);
        nextCycle();
        sent_line_cntr = '0;
        nextCycle();
    endtask

    function automatic logic [DW_VX-1:0] mkAux(input bit s, input bit e);
        logic [DW_VX-1:0] a;
        a = '0;
        a[AUX_SOF] = s;
        a[AUX_EOL] = e;
        return a;
    endfunction

    task automatic clearLogs();
        wrLog.delete();
        rcvdLog.delete();
        errPulses = 0;
    endtask

    task automatic cleanFrame();
        iw = 16'd4;
        ih = 16'd3;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(DW_VD'(i), mkAux(i == 1, (i % 4) == 0));
        end
        finishFrame(3);
    endtask

    initial begin
        int w;
        int h;
        int realCnt;

        // Reset held with val high
        rstb = 1'b0;
        val  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy", 32'(rdy), 32'd0);
        checkOutput("reset_wr_en", 32'(line_wr_en), 32'd0);
        checkOutput("reset_wr_dat", 32'(line_wr_dat), 32'd0);
        checkOutput("reset_rcvd", 32'(rcvd_line_cntr), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        nextCycle();
        val  = 1'b0;
        rstb = 1'b1;
        nextCycle();

        // Clean 4x3 frame
        clearLogs();
        cleanFrame();
        checkOutput("clean_wr_count", 32'(wrLog.size()), 32'd16);
        if (wrLog.size() == 16) begin
            checkOutput("clean_wr3", 32'(wrLog[3]), {17'd0, 1'b1, 14'd4});
            checkOutput("clean_wr11", 32'(wrLog[11]), {17'd0, 1'b1, 14'd12});
            checkOutput("clean_pad12", 32'(wrLog[12]), 32'd0);
            checkOutput("clean_pad15", 32'(wrLog[15]), 32'd0);
            checkOutput("clean_rcvd2", 32'(rcvdLog[2]), 32'd0);
            checkOutput("clean_rcvd3", 32'(rcvdLog[3]), 32'd1);
            checkOutput("clean_rcvd7", 32'(rcvdLog[7]), 32'd2);
            checkOutput("clean_rcvd11", 32'(rcvdLog[11]), 32'd3);
        end
        checkOutput("clean_err_count", 32'(errPulses), 32'd0);

        // Backpressure mid-line and during padding
        clearLogs();
        iw = 16'd4;
        ih = 16'd3;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) begin
                afullForce = 1'b1;
                repeat (3) nextCycle();
                afullForce = 1'b0;
            end
            applyStimulus(DW_VD'(i), mkAux(i == 1, (i % 4) == 0));
        end
        afullForce = 1'b1;
        nextCycle();
        repeat (3) nextCycle();
        afullForce = 1'b0;
        finishFrame(3);
        realCnt = 0;
        foreach (wrLog[k]) if (wrLog[k][DW_VD]) realCnt++;
        checkOutput("bp_wr_count", 32'(wrLog.size()), 32'd16);
        checkOutput("bp_real_count", 32'(realCnt), 32'd12);
        if (wrLog.size() == 16) checkOutput("bp_wr11", 32'(wrLog[11]), {17'd0, 1'b1, 14'd12});

        // Beats without sof in IDLE are dropped
        clearLogs();
        iw = 16'd2;
        ih = 16'd1;
        applyStimulus(14'd7, mkAux(0, 0));
        applyStimulus(14'd8, mkAux(0, 0));
        applyStimulus(14'd9, mkAux(1, 0));
        applyStimulus(14'd10, mkAux(0, 1));
        finishFrame(1);
        checkOutput("nosof_err_count", 32'(errPulses), ERR_EN ? 32'd2 : 32'd0);
        checkOutput("nosof_wr_count", 32'(wrLog.size()), 32'd4);
        if (wrLog.size() > 0) checkOutput("nosof_wr0", 32'(wrLog[0]), {17'd0, 1'b1, 14'd9});

        // Early eol does not end the line
        clearLogs();
        iw = 16'd4;
        ih = 16'd1;
        applyStimulus(14'd21, mkAux(1, 0));
        applyStimulus(14'd22, mkAux(0, 1));
        applyStimulus(14'd23, mkAux(0, 0));
        applyStimulus(14'd24, mkAux(0, 1));
        finishFrame(1);
        checkOutput("eol_err_count", 32'(errPulses), ERR_EN ? 32'd1 : 32'd0);
        checkOutput("eol_wr_count", 32'(wrLog.size()), 32'd8);
        if (wrLog.size() == 8) begin
            checkOutput("eol_rcvd1", 32'(rcvdLog[1]), 32'd0);
            checkOutput("eol_rcvd3", 32'(rcvdLog[3]), 32'd1);
        end

        // Reset in the middle of a frame
        iw = 16'd4;
        ih = 16'd3;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(DW_VD'(i), mkAux(i == 1, (i % 4) == 0));
        end
        rstb = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rdy", 32'(rdy), 32'd0);
        checkOutput("midrst_rcvd", 32'(rcvd_line_cntr), 32'd0);
        checkOutput("midrst_wr_en", 32'(line_wr_en), 32'd0);
        nextCycle();
        rstb = 1'b1;
        nextCycle();
        clearLogs();
        cleanFrame();
        checkOutput("midrst_wr_count", 32'(wrLog.size()), 32'd16);
        if (wrLog.size() == 16) checkOutput("midrst_rcvd3", 32'(rcvdLog[3]), 32'd1);

        // Randomized frames with random gaps, afull, sideband faults and iw/ih churn
        afullRand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            w  = $urandom_range(1, 5);
            h  = $urandom_range(1, 4);
            iw = 16'(w);
            ih = 16'(h);
            if ($urandom_range(0, 3) == 0) applyStimulus(DW_VD'($urandom), mkAux(0, 0));
            for (int p = 0; p < w * h; p++) begin
                bit s;
                bit e;
                s = (p == 0) || ($urandom_range(0, 9) == 0);
                e = ((p % w) == w - 1);
                if ($urandom_range(0, 6) == 0) e = !e;
                applyStimulus(DW_VD'($urandom), mkAux(s, e));
                if (p == 0) begin
                    iw = 16'($urandom_range(1, 9));
                    ih = 16'($urandom_range(1, 9));
                end
                repeat ($urandom_range(0, 2)) nextCycle();
            end
            finishFrame(h);
        end
        afullRand = 1'b0;
        repeat (3) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/median_filter_rx.md
# median_filter_rx

Receive-side framer for the median filter. It accepts the incoming pixel stream (aux/dat/val/rdy) from the RX FIFO and writes each pixel, tagged with a mask bit, into the head of the line-FIFO cascade. It publishes `rcvd_line_cntr`, which `median_filter_filt` uses for throttling. At end of frame it appends SIZE/2 masked padding lines so the last image lines reach the middle FIFO, then re-arms for the next frame after the transmit side has drained.

## Interface
- SIZE, 3: filter window size (odd); sets padding line count SIZE/2
- DW_VD, 14: pixel data width
- DW_VX, 4: aux width; bit0 = sof, bit1 = eol, others ignored
- DW_MD, 16: width of iw/ih and of the pixel counter
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- iw  in  DW_MD  image width in pixels, ≥1
- ih  in  DW_MD  image height in lines, ≥1
- aux  in  DW_VX  sideband for the current beat
- dat  in  DW_VD  pixel data
- val  in  1  beat valid
- rdy  out  1  block can accept a beat
- line_fifo_afull  in  1  head line FIFO almost full (≥2 free entries remain when deasserted)
- line_wr_en  out  1  head line FIFO write strobe
- line_wr_dat  out  DW_VD+1  {mask, pixel}; mask=1 real pixel, 0 padding
- rcvd_line_cntr  out  16  complete lines written this frame
- sent_line_cntr  in  16  lines emitted by the transmit side
- frame_err  out  1  one-cycle protocol error pulse

## Operation
- Beat transfer occurs when val && rdy at a rising clk edge.
- rdy = (state==IDLE || state==RECV) && !line_fifo_afull. This is combinational from the registered state and the afull input.
- States:
  - IDLE: beats without sof are dropped (accepted, not written). In `MF_RX_ERR_CHK_EN` builds each dropped beat pulses frame_err. A beat with sof latches iw/ih into iw_q/ih_q, is written as pixel 0, and moves the FSM to RECV.
  - RECV: each transfer writes {1, dat}; pix_cntr increments.
    - On the transfer where pix_cntr == iw_q-1: pix_cntr clears and line_cntr increments.
    - If that was line ih_q-1, go to PAD.
    - The pixel counter is authoritative. eol never terminates a line early and never extends one.
  - PAD: rdy=0. Write {1'b0, 0} once per cycle while !line_fifo_afull, for (SIZE/2)*iw_q words. Then go to DRAIN. If SIZE/2 == 0, go directly to DRAIN.
  - DRAIN: rdy=0, no writes. When sent_line_cntr == ih_q, clear rcvd_line_cntr to 0 and go to IDLE. The transmit side then sees 0 and resets its own counter.
- rcvd_line_cntr counts real lines only. It saturates at ih_q and never counts padding.
- Widths: pix_cntr and line_cntr are DW_MD bits. Comparisons use the latched iw_q/ih_q, so iw/ih changes mid-frame have no effect.
- Error checks (only with `MF_RX_ERR_CHK_EN`):
  - sof while in RECV: frame_err pulse; the sof bit is ignored and the beat is stored as a normal pixel.
  - eol asserted with pix_cntr != iw_q-1: frame_err pulse.
  - eol deasserted on the line's last pixel: frame_err pulse.
  - Multiple errors in one beat produce a single pulse.

## Timing
- Reset values: rdy=0 (state IDLE, but held at 0 while rstb is low), line_wr_en=0, line_wr_dat=0, rcvd_line_cntr=0, frame_err=0. Internal counters are 0 and the state is IDLE.
- Write latency: line_wr_en and line_wr_dat are registered and assert one cycle after the accepting edge.
- rcvd_line_cntr updates on the same edge that line_wr_en asserts for the line's last pixel, so the count never leads the data.
- frame_err asserts one cycle after the offending beat, for exactly one cycle.
- PAD writes run back-to-back at one per cycle. Each cycle with afull high stalls one write; no write is skipped.
- DRAIN to IDLE: rcvd_line_cntr reads 0 one cycle after the sent_line_cntr == ih_q condition is sampled. rdy rises in that same cycle unless afull is high.
- If afull rises in a cycle, rdy falls in that same cycle; the in-flight registered write still completes.
- Reset asserted mid-frame returns the block to its reset values immediately. The line FIFOs are reset by their owner.

## Configuration
- `MF_RX_ERR_CHK_EN` defined: the sof, eol and dropped-beat checks are built and drive frame_err.
- `MF_RX_ERR_CHK_EN` undefined: check logic is removed and frame_err is tied to 0. sof-based frame start in IDLE and the pixel-count-based line end are unchanged.

## Structure
- Shared package `median_filter_pkg`:
  - state encodings MF_RX_IDLE, MF_RX_RECV, MF_RX_PAD, MF_RX_DRAIN
  - aux bit indices AUX_SOF=0, AUX_EOL=1, AUX_CORE=2, used by both the RX and TX sides
  - mask bit position DW_VD in the line FIFO word
- No sub-module: a single FSM with counters. The write-path output register stays inline.

## Test plan
- Reset: hold rstb low 5 cycles with val=1 -> rdy, line_wr_en, line_wr_dat, rcvd_line_cntr and frame_err all stay 0.
- Clean frame: SIZE=3, iw=4, ih=3, 12 beats dat=1..12 with sof on beat 1 and eol on beats 4/8/12 -> 12 writes {1,1..12}, rcvd_line_cntr 1, 2, 3 coincident with writes 4/8/12, then 4 writes of {0,0}. rdy stays 0 until sent_line_cntr=3 is driven; then rcvd_line_cntr=0 and rdy=1 the next cycle.
- Backpressure: afull high for 3 cycles mid-line and again during PAD -> no transfers while rdy=0, no lost or duplicated words, total write count still 16.
- Missing sof: 2 beats without sof in IDLE, then a sof beat -> the first 2 beats produce no writes and 2 frame_err pulses; the sof beat is written as pixel 0.
- Bad eol: iw=4, eol on pixel 1 -> one frame_err pulse; the line still ends after pixel 3 and rcvd_line_cntr increments once.
- Reset mid-frame: assert rstb after 6 of 12 beats -> all outputs return to 0; the next sof starts a clean frame with rcvd_line_cntr counting from 1.
